// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter that shares one single-port registered RAM between a writer
// and a reader, managing the RAM as a circular buffer with full/empty/overflow status.
module ram_port_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              ovf_clr,
    output logic              overflow,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic [1:0]        state,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_LVL = DEPTH[ADDR_W:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RDW  = 2'd3
    } state_t;

    state_t            st_q;
    state_t            st_nxt;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic              last_wr;
    logic              wr_ok;
    logic              rd_ok;
    logic              go_wr;
    logic              go_rd;
    logic              ovf_set;

    // Arbitration: decisions are only made in IDLE, so every grant is a
    // registered pulse that lines up with the WR/RD state it belongs to.
    always_comb begin
        st_nxt  = st_q;
        wr_ok   = wr_req & ~full;
        rd_ok   = rd_req & ~empty;
        go_wr   = 1'b0;
        go_rd   = 1'b0;
        ovf_set = 1'b0;
        case (st_q)
            IDLE: begin
                ovf_set = wr_req & full;
                if (wr_ok && rd_ok) begin
                    go_wr = ~last_wr;
                    go_rd = last_wr;
                end else begin
                    go_wr = wr_ok;
                    go_rd = rd_ok;
                end
                if (go_wr) begin
                    st_nxt = WR;
                end else if (go_rd) begin
                    st_nxt = RD;
                end
            end
            WR:      st_nxt = IDLE;
            RD:      st_nxt = RDW;
            RDW:     st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q <= IDLE;
        end else begin
            st_q <= st_nxt;
        end
    end

    // RAM port drive: address and write data are set up on entry to WR/RD and
    // then held, so the macro sees stable inputs outside the access cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_gnt    <= 1'b0;
            rd_gnt    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            wr_gnt <= go_wr;
            rd_gnt <= go_rd;
            ram_we <= go_wr;
            if (go_wr) begin
                ram_addr  <= wptr;
                ram_wdata <= wr_data;
            end else if (go_rd) begin
                ram_addr <= rptr;
            end
        end
    end

    // Read return: the RAM answers one cycle after RD, captured during RDW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= (st_q == RDW);
            if (st_q == RDW) begin
                rd_data <= ram_rdata;
            end
        end
    end

    // Pointer and occupancy bookkeeping commits as each access completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            level   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            last_wr <= 1'b0;
        end else if (st_q == WR) begin
            wptr    <= wptr + 1'b1;
            level   <= level + 1'b1;
            full    <= ((level + 1'b1) == FULL_LVL);
            empty   <= 1'b0;
            last_wr <= 1'b1;
        end else if (st_q == RD) begin
            rptr    <= rptr + 1'b1;
            level   <= level - 1'b1;
            full    <= 1'b0;
            empty   <= (level == {{ADDR_W{1'b0}}, 1'b1});
            last_wr <= 1'b0;
        end
    end

    // Sticky overflow; a new overflow in the same cycle as a clear must not be lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    assign state = st_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural registered single-port RAM.
module tb_ram_port_arbiter;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;
    logic              rd_req;
    logic              rd_gnt;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              ovf_clr;
    logic              overflow;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic [1:0]        state;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int total = 0;
    int bad   = 0;

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .wr_gnt    (wr_gnt),
        .rd_req    (rd_req),
        .rd_gnt    (rd_gnt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .ovf_clr   (ovf_clr),
        .overflow  (overflow),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .state     (state),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Requests a write, waits for its grant, returns what the RAM port showed in the WR cycle.
    task automatic do_write(input logic [DATA_W-1:0] d, output int n,
                            output logic [ADDR_W-1:0] addr, output logic [DATA_W-1:0] wd,
                            output logic we);
        wr_req  = 1'b1;
        wr_data = d;
        n = 0;
        do begin
            tick();
            n++;
        end while (!wr_gnt && n < 40);
        chk("wr_gnt_seen", wr_gnt, 1);
        addr = ram_addr;
        wd   = ram_wdata;
        we   = ram_we;
        wr_req = 1'b0;
        tick();
    endtask

    task automatic do_read(output logic [ADDR_W-1:0] addr, output logic vld,
                           output logic [DATA_W-1:0] d);
        int n;
        rd_req = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rd_gnt && n < 40);
        chk("rd_gnt_seen", rd_gnt, 1);
        addr   = ram_addr;
        rd_req = 1'b0;
        tick();
        tick();
        vld = rd_valid;
        d   = rd_data;
    endtask

    initial begin
        int                n;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              b;
        logic              seen;
        logic [3:0]        seq;
        int                g;

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        rst = 1'b1; wr_req = 1'b0; wr_data = '0; rd_req = 1'b0; ovf_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // idle after reset
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_state", state, 0);
            chk("idle_empty", empty, 1);
            chk("idle_full", full, 0);
            chk("idle_level", level, 0);
            chk("idle_we", ram_we, 0);
            chk("idle_ovf", overflow, 0);
        end

        // single write then read back
        do_write(8'hA5, n, a, d, b);
        chk("w1_latency", n, 1);
        chk("w1_addr", a, 0);
        chk("w1_wdata", d, 8'hA5);
        chk("w1_we", b, 1);
        chk("w1_level", level, 1);
        chk("w1_we_off", ram_we, 0);
        chk("w1_empty", empty, 0);
        do_read(a, b, d);
        chk("r1_addr", a, 0);
        chk("r1_valid", b, 1);
        chk("r1_data", d, 8'hA5);
        chk("r1_level", level, 0);
        chk("r1_empty", empty, 1);
        tick();
        chk("r1_valid_pulse", rd_valid, 0);

        // fill to full, overflow, clear, wrap
        do_reset();
        for (int i = 0; i < 16; i++) begin
            do_write(8'h10 + 8'(i), n, a, d, b);
            chk("fill_addr", a, i);
        end
        chk("fill_level", level, 16);
        chk("fill_full", full, 1);
        chk("fill_empty", empty, 0);
        wr_req  = 1'b1;
        wr_data = 8'h77;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (wr_gnt) seen = 1'b1;
        end
        chk("ovf_no_gnt", seen, 0);
        chk("ovf_set", overflow, 1);
        chk("ovf_state", state, 0);
        chk("ovf_level", level, 16);
        ovf_clr = 1'b1;
        tick();
        chk("ovf_set_wins", overflow, 1);
        wr_req = 1'b0;
        tick();
        chk("ovf_cleared", overflow, 0);
        ovf_clr = 1'b0;
        do_read(a, b, d);
        chk("full_rd_addr", a, 0);
        chk("full_rd_data", d, 8'h10);
        chk("full_rd_level", level, 15);
        chk("full_rd_notfull", full, 0);
        do_write(8'h77, n, a, d, b);
        chk("wrap_addr", a, 0);
        chk("wrap_level", level, 16);
        chk("wrap_full", full, 1);

        // alternating grants on a tie with level 4
        do_reset();
        for (int i = 0; i < 5; i++) do_write(8'h40 + 8'(i), n, a, d, b);
        do_read(a, b, d);
        chk("tie_pre_level", level, 4);
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        wr_data = 8'h55;
        g = 0;
        seq = '0;
        for (int i = 0; i < 40 && g < 4; i++) begin
            tick();
            if (wr_gnt) begin seq[3-g] = 1'b1; g++; end
            else if (rd_gnt) begin seq[3-g] = 1'b0; g++; end
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        chk("tie_count", g, 4);
        chk("tie_seq_WRWR", seq, 4'b1010);
        tick();
        tick();
        tick();
        chk("tie_level", level, 4);

        // read on empty buffer waits, then is served after a write
        do_reset();
        rd_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (rd_gnt) seen = 1'b1;
        end
        chk("empty_no_rgnt", seen, 0);
        chk("empty_state", state, 0);
        chk("empty_ovf", overflow, 0);
        do_write(8'h3C, n, a, d, b);
        chk("empty_w_addr", a, 0);
        do_read(a, b, d);
        chk("empty_r_addr", a, 0);
        chk("empty_r_valid", b, 1);
        chk("empty_r_data", d, 8'h3C);
        chk("empty_r_level", level, 0);

        // asynchronous reset in the middle of a WR cycle
        do_reset();
        do_write(8'h01, n, a, d, b);
        do_write(8'h02, n, a, d, b);
        chk("arst_pre_level", level, 2);
        wr_req  = 1'b1;
        wr_data = 8'h99;
        tick();
        chk("arst_in_wr", ram_we, 1);
        chk("arst_in_wr_state", state, 1);
        wr_req = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_we", ram_we, 0);
        chk("arst_state", state, 0);
        chk("arst_level", level, 0);
        chk("arst_gnt", wr_gnt, 0);
        chk("arst_empty", empty, 1);
        tick();
        rst = 1'b0;
        tick();
        chk("arst_level_after", level, 0);
        chk("arst_state_after", state, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
